// File: rtl/demux1_2_stream.sv
// 1:2 stream demultiplexer with a one-entry output register per port.
// Optional delivered-beat counters a_cnt/b_cnt are built when DEMUX_STATS_EN is defined.
module demux1_2_stream #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         s,
  output logic         in_ready,
  output logic         a_valid,
  output logic [W-1:0] a_data,
  input  logic         a_ready,
  output logic         b_valid,
  output logic [W-1:0] b_data,
  input  logic         b_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]   a_cnt,
  output logic [7:0]   b_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t a_state, a_state_nxt;
  state_t b_state, b_state_nxt;
  logic   a_load, b_load;
  logic   a_acc, b_acc;

  assign a_valid = (a_state == ST_FULL);
  assign b_valid = (b_state == ST_FULL);

  // Ready reflects only the selected port; a full slot may accept when it drains this cycle.
  assign in_ready = s ? (~b_valid | b_ready) : (~a_valid | a_ready);

  assign a_acc = in_valid & ~s & in_ready;
  assign b_acc = in_valid &  s & in_ready;

  // State registers; reset discards held and incoming beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_state <= ST_EMPTY;
      b_state <= ST_EMPTY;
    end else begin
      a_state <= a_state_nxt;
      b_state <= b_state_nxt;
    end
  end

  // Port a next state and load enable.
  always_comb begin
    a_state_nxt = a_state;
    a_load      = 1'b0;
    case (a_state)
      ST_EMPTY: begin
        if (a_acc) begin
          a_state_nxt = ST_FULL;
          a_load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (a_acc) begin
          a_load = 1'b1;
        end else if (a_ready) begin
          a_state_nxt = ST_EMPTY;
        end
      end
      default: a_state_nxt = ST_EMPTY;
    endcase
  end

  // Port b next state and load enable.
  always_comb begin
    b_state_nxt = b_state;
    b_load      = 1'b0;
    case (b_state)
      ST_EMPTY: begin
        if (b_acc) begin
          b_state_nxt = ST_FULL;
          b_load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (b_acc) begin
          b_load = 1'b1;
        end else if (b_ready) begin
          b_state_nxt = ST_EMPTY;
        end
      end
      default: b_state_nxt = ST_EMPTY;
    endcase
  end

  // Output data registers hold their beat until replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_load) a_data <= in_data;
      if (b_load) b_data <= in_data;
    end
  end

`ifdef DEMUX_STATS_EN
  // Wrapping counters of output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt <= 8'd0;
      b_cnt <= 8'd0;
    end else begin
      if (a_valid && a_ready) a_cnt <= a_cnt + 8'd1;
      if (b_valid && b_ready) b_cnt <= b_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed self-checking bench for demux1_2_stream (counter checks when DEMUX_STATS_EN is defined).
module tb_demux1_2_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       s;
  logic       in_ready;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
`ifdef DEMUX_STATS_EN
  logic [7:0] a_cnt;
  logic [7:0] b_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux1_2_stream #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .s        (s),
    .in_ready (in_ready),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready)
`ifdef DEMUX_STATS_EN
    ,
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; s = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    tick();
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'h00);
    chk("rst_b_data", 32'(b_data), 32'h00);
    rst = 1'b0;
    #1 chk("post_rst_ready_s0", 32'(in_ready), 32'd1);
    s = 1'b1;
    #1 chk("post_rst_ready_s1", 32'(in_ready), 32'd1);

    // Basic route to port a
    in_valid = 1'b1; s = 1'b0; in_data = 8'h3C; a_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("route_a_valid", 32'(a_valid), 32'd1);
    chk("route_a_data", 32'(a_data), 32'h3C);
    chk("route_b_valid", 32'(b_valid), 32'd0);
    tick();
    chk("route_a_drained", 32'(a_valid), 32'd0);

    // Backpressure on port b
    in_valid = 1'b1; s = 1'b1; in_data = 8'h11; b_ready = 1'b0;
    tick();
    in_data = 8'h22;
    #1 chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("bp_b_valid_hold", 32'(b_valid), 32'd1);
    chk("bp_b_data_hold", 32'(b_data), 32'h11);
    b_ready = 1'b1;
    #1 chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_valid_next", 32'(b_valid), 32'd1);
    chk("bp_b_data_next", 32'(b_data), 32'h22);
    tick();
    chk("bp_b_drained", 32'(b_valid), 32'd0);

    // Independence: port a stalled full, port b streams
    a_ready = 1'b0; in_valid = 1'b1; s = 1'b0; in_data = 8'hAA;
    tick();
    s = 1'b1; b_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      #1 chk("ind_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("ind_b_valid", 32'(b_valid), 32'd1);
      chk("ind_b_data", 32'(b_data), 32'(i));
      chk("ind_a_valid", 32'(a_valid), 32'd1);
      chk("ind_a_data", 32'(a_data), 32'hAA);
    end
    in_valid = 1'b0;
    tick();
    chk("ind_b_drained", 32'(b_valid), 32'd0);

    // Simultaneous drain and refill of port a
    a_ready = 1'b1; in_valid = 1'b1; s = 1'b0; in_data = 8'h55;
    tick();
    chk("sim_a_data_55", 32'(a_data), 32'h55);
    in_data = 8'h66;
    tick();
    in_valid = 1'b0; a_ready = 1'b0;
    chk("sim_a_valid", 32'(a_valid), 32'd1);
    chk("sim_a_data_66", 32'(a_data), 32'h66);
    tick();
    chk("sim_a_hold", 32'(a_data), 32'h66);

    // Fill port b, then reset mid-operation
    b_ready = 1'b0; in_valid = 1'b1; s = 1'b1; in_data = 8'h77;
    tick();
    chk("mid_a_full", 32'(a_valid), 32'd1);
    chk("mid_b_full", 32'(b_valid), 32'd1);
`ifdef DEMUX_STATS_EN
    chk("mid_a_cnt", 32'(a_cnt), 32'd3);
    chk("mid_b_cnt", 32'(b_cnt), 32'd6);
`endif
    rst = 1'b1; s = 1'b0; in_data = 8'h99; a_ready = 1'b1; b_ready = 1'b1;
    tick();
    chk("rst2_a_valid", 32'(a_valid), 32'd0);
    chk("rst2_b_valid", 32'(b_valid), 32'd0);
    chk("rst2_a_data", 32'(a_data), 32'h00);
    chk("rst2_b_data", 32'(b_data), 32'h00);
`ifdef DEMUX_STATS_EN
    chk("rst2_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst2_b_cnt", 32'(b_cnt), 32'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst2_no_a_beat", 32'(a_valid), 32'd0);
    chk("rst2_no_b_beat", 32'(b_valid), 32'd0);

`ifdef DEMUX_STATS_EN
    // Deliver 257 beats on port a to exercise counter wrap
    a_ready = 1'b1; in_valid = 1'b1; s = 1'b0;
    for (int i = 0; i < 257; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_a_cnt", 32'(a_cnt), 32'd1);
    chk("wrap_b_cnt", 32'(b_cnt), 32'd0);
    chk("wrap_a_drained", 32'(a_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
